// File: rtl/intrapred_pkg.sv
// Shared types and helpers for the intra-prediction frame sequencer.
// Holds the FSM state encoding, enabler bit positions and frame geometry math.
package intrapred_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NP,
    ST_PRED,
    ST_RES,
    ST_SAD,
    ST_OUT
  } ip_state_t;

  localparam int EN_NP   = 0;
  localparam int EN_PRED = 1;
  localparam int EN_RES  = 2;
  localparam int EN_SAD  = 3;

  localparam int IDX_W = 32;

  function automatic int num_luma_blk(int width, int length);
    return (width / 4) * (length / 4);
  endfunction

  // One-hot datapath stage enable for a given state; IDLE and OUT enable nothing.
  function automatic logic [3:0] stage_enable(ip_state_t st);
    logic [3:0] en;
    en = '0;
    case (st)
      ST_NP:   en[EN_NP]   = 1'b1;
      ST_PRED: en[EN_PRED] = 1'b1;
      ST_RES:  en[EN_RES]  = 1'b1;
      ST_SAD:  en[EN_SAD]  = 1'b1;
      default: en = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/intrapred_sequencer_if.sv
// Control/handshake bundle between the frame sequencer and its neighbours.
// master = sequencer side, slave = frame controller / datapath / downstream side.
interface intrapred_sequencer_if;
  import intrapred_pkg::*;

  logic             start;
  logic             abort;
  logic             blk_ready;
  logic [3:0]       enabler;
  logic [IDX_W-1:0] mbnumber_luma4x4;
  logic [IDX_W-1:0] mbnumber_chromab8x8;
  logic [IDX_W-1:0] mbnumber_chromar8x8;
  logic             blk_valid;
  logic             chroma_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    input  start, abort, blk_ready,
    output enabler, mbnumber_luma4x4, mbnumber_chromab8x8, mbnumber_chromar8x8,
    output blk_valid, chroma_valid, busy, frame_done
  );

  modport slave (
    output start, abort, blk_ready,
    input  enabler, mbnumber_luma4x4, mbnumber_chromab8x8, mbnumber_chromar8x8,
    input  blk_valid, chroma_valid, busy, frame_done
  );

endinterface

// File: rtl/intrapred_blk_counter.sv
// Luma block step counter with clear/increment and a last-block flag.
// Exposes the next count and the matching chroma index (four luma steps per chroma block).
module intrapred_blk_counter
  import intrapred_pkg::*;
#(
  parameter int N_LUMA = 57600
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [IDX_W-1:0] count_d_o,
  output logic [IDX_W-1:0] chroma_d_o,
  output logic             last_o
);

  logic [IDX_W-1:0] count_q, count_d;

  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + IDX_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_d_o  = count_d;
  assign chroma_d_o = count_d >> 2;
  assign last_o     = (count_q == IDX_W'(N_LUMA - 1));

endmodule

// File: rtl/intrapred_sequencer.sv
// Frame-level intra-prediction controller: walks all blocks, pulses the four
// datapath stages per block, then holds a block-valid handshake until accepted.
module intrapred_sequencer
  import intrapred_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int LENGTH = 720
) (
  input  logic                  clk,
  input  logic                  reset,
  intrapred_sequencer_if.master ip_if
);

  localparam int N_LUMA = num_luma_blk(WIDTH, LENGTH);

  ip_state_t        state_q, state_d;
  logic             cnt_clr, cnt_inc, cnt_last;
  logic [IDX_W-1:0] cnt_next, cnt_chroma_next;
  logic             frame_done_d;
  logic             load_idx;

  logic [IDX_W-1:0] luma_q, luma_d;
  logic [IDX_W-1:0] chroma_q, chroma_d;
  logic [3:0]       enabler_q;
  logic             blk_valid_q, chroma_valid_q, busy_q, frame_done_q;

  intrapred_blk_counter #(
    .N_LUMA (N_LUMA)
  ) u_blk_counter (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .count_d_o  (cnt_next),
    .chroma_d_o (cnt_chroma_next),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ip_if.start && !ip_if.abort) begin
          state_d = ST_NP;
          cnt_clr = 1'b1;
        end
      end
      ST_NP:   state_d = ST_PRED;
      ST_PRED: state_d = ST_RES;
      ST_RES:  state_d = ST_SAD;
      ST_SAD:  state_d = ST_OUT;
      ST_OUT: begin
        if (ip_if.blk_ready) begin
          if (cnt_last) begin
            state_d      = ST_IDLE;
            cnt_clr      = 1'b1;
            frame_done_d = 1'b1;
          end else begin
            state_d = ST_NP;
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort outranks the downstream handshake and suppresses completion.
    if (ip_if.abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      cnt_clr      = 1'b1;
      cnt_inc      = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // Block indices only move on entry to NP, so they hold through OUT and IDLE.
  assign load_idx = (state_d == ST_NP);
  assign luma_d   = load_idx ? cnt_next        : luma_q;
  assign chroma_d = load_idx ? cnt_chroma_next : chroma_q;

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      luma_q         <= '0;
      chroma_q       <= '0;
      enabler_q      <= '0;
      blk_valid_q    <= 1'b0;
      chroma_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      luma_q         <= luma_d;
      chroma_q       <= chroma_d;
      enabler_q      <= stage_enable(state_d);
      blk_valid_q    <= (state_d == ST_OUT);
      chroma_valid_q <= (state_d == ST_OUT) && (luma_d[1:0] == 2'b11);
      busy_q         <= (state_d != ST_IDLE);
      frame_done_q   <= frame_done_d;
    end
  end

  assign ip_if.enabler             = enabler_q;
  assign ip_if.mbnumber_luma4x4    = luma_q;
  assign ip_if.mbnumber_chromab8x8 = chroma_q;
  assign ip_if.mbnumber_chromar8x8 = chroma_q;
  assign ip_if.blk_valid           = blk_valid_q;
  assign ip_if.chroma_valid        = chroma_valid_q;
  assign ip_if.busy                = busy_q;
  assign ip_if.frame_done          = frame_done_q;

endmodule

// File: tb/tb_intrapred_sequencer.sv
// Directed bench for intrapred_sequencer on a 16x8 frame (8 luma blocks).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_intrapred_sequencer;

  localparam int WIDTH  = 16;
  localparam int LENGTH = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  intrapred_sequencer_if ifc ();

  intrapred_sequencer #(
    .WIDTH  (WIDTH),
    .LENGTH (LENGTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ip_if (ifc)
  );

  always #5 clk = ~clk;

  // {enabler, blk_valid, chroma_valid, busy, frame_done, luma, chroma}
  function automatic logic [71:0] obs_vec();
    return {ifc.enabler, ifc.blk_valid, ifc.chroma_valid, ifc.busy, ifc.frame_done,
            ifc.mbnumber_luma4x4, ifc.mbnumber_chromab8x8};
  endfunction

  // Expected outputs kk cycles after start was sampled, blk_ready high throughout.
  function automatic logic [71:0] exp_vec(int kk);
    logic [3:0]  en;
    logic        bv, cv, bz, dn;
    logic [31:0] luma;
    int          blk, ph;
    en = '0; bv = 1'b0; cv = 1'b0; bz = 1'b0; dn = 1'b0;
    if (kk >= 1 && kk <= 40) begin
      blk  = (kk - 1) / 5;
      ph   = (kk - 1) % 5;
      if (ph < 4) en = 4'b0001 << ph;
      bv   = (ph == 4);
      cv   = bv && ((blk % 4) == 3);
      bz   = 1'b1;
      luma = 32'(blk);
    end else begin
      luma = 32'd7;
      dn   = (kk == 41);
    end
    return {en, bv, cv, bz, dn, luma, luma >> 2};
  endfunction

  // Leaves the caller on the falling edge just after start was sampled.
  task automatic pulse_start();
    ifc.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_vec() !== 72'd0) $display("FAIL reset_values got %h want %h", obs_vec(), 72'd0);
    else n_pass++;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_vec() !== 72'd0) $display("FAIL idle_after_reset got %h want %h", obs_vec(), 72'd0);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    pulse_start();
    for (int k = 1; k <= 45; k++) begin
      n_checks++;
      if (obs_vec() !== exp_vec(k))
        $display("FAIL frame k=%0d got %h want %h", k, obs_vec(), exp_vec(k));
      else n_pass++;
      n_checks++;
      if ($countones(ifc.enabler) > 1 || ifc.mbnumber_chromar8x8 !== ifc.mbnumber_chromab8x8)
        $display("FAIL frame_onehot_cr k=%0d got en=%b cr=%0d want onehot cr=%0d",
                 k, ifc.enabler, ifc.mbnumber_chromar8x8, ifc.mbnumber_chromab8x8);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    int kk;
    pulse_start();
    for (int k = 1; k <= 45; k++) begin
      kk = (k <= 15) ? k : (k <= 18) ? 15 : k - 3;
      n_checks++;
      if (obs_vec() !== exp_vec(kk))
        $display("FAIL stall k=%0d got %h want %h", k, obs_vec(), exp_vec(kk));
      else n_pass++;
      ifc.blk_ready = !(k >= 15 && k <= 17);
      @(negedge clk);
    end
    ifc.blk_ready = 1'b1;
  endtask

  task automatic test_abort();
    logic [71:0] idle_exp;
    pulse_start();
    for (int k = 1; k <= 28; k++) begin
      n_checks++;
      if (obs_vec() !== exp_vec(k))
        $display("FAIL abort_pre k=%0d got %h want %h", k, obs_vec(), exp_vec(k));
      else n_pass++;
      if (k < 28) @(negedge clk);
    end
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    idle_exp = {4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd1};
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (obs_vec() !== idle_exp)
        $display("FAIL abort_idle c=%0d got %h want %h", k, obs_vec(), idle_exp);
      else n_pass++;
      @(negedge clk);
    end
    pulse_start();
    n_checks++;
    if (obs_vec() !== exp_vec(1))
      $display("FAIL abort_restart got %h want %h", obs_vec(), exp_vec(1));
    else n_pass++;
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    n_checks++;
    if ({ifc.busy, ifc.enabler, ifc.frame_done} !== 6'd0)
      $display("FAIL abort_in_np got %b want %b", {ifc.busy, ifc.enabler, ifc.frame_done}, 6'd0);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    pulse_start();
    for (int k = 1; k <= 45; k++) begin
      n_checks++;
      if (obs_vec() !== exp_vec(k))
        $display("FAIL start_busy k=%0d got %h want %h", k, obs_vec(), exp_vec(k));
      else n_pass++;
      ifc.start = (k == 3) || (k == 20) || (k == 38);
      @(negedge clk);
    end
    ifc.start = 1'b0;
  endtask

  task automatic test_start_abort_idle();
    ifc.start = 1'b1;
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs_vec() !== exp_vec(45))
        $display("FAIL start_abort_idle c=%0d got %h want %h", k, obs_vec(), exp_vec(45));
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    repeat (3) @(negedge clk);
    n_checks++;
    if (ifc.enabler !== 4'b1000) $display("FAIL reset_mid_sad got %b want %b", ifc.enabler, 4'b1000);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== 72'd0) $display("FAIL reset_async got %h want %h", obs_vec(), 72'd0);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== 72'd0)
        $display("FAIL reset_release c=%0d got %h want %h", k, obs_vec(), 72'd0);
      else n_pass++;
    end
  endtask

  initial begin
    ifc.start     = 1'b0;
    ifc.abort     = 1'b0;
    ifc.blk_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_stall();
    test_abort();
    test_start_ignored();
    test_start_abort_idle();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
